// File: rtl/micro_sequencer_pkg.sv
// Shared definitions for the micro_sequencer: next-address select codes,
// sequencer state encoding and flag bit positions within i_flags.
package useq_pkg;

  localparam logic [2:0] MS_INC = 3'd0;
  localparam logic [2:0] MS_NA  = 3'd1;
  localparam logic [2:0] MS_C   = 3'd2;
  localparam logic [2:0] MS_V   = 3'd3;
  localparam logic [2:0] MS_Z   = 3'd4;
  localparam logic [2:0] MS_N   = 3'd5;
  localparam logic [2:0] MS_NZ  = 3'd6;
  localparam logic [2:0] MS_MAP = 3'd7;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    WAIT_MEM = 2'd1,
    HALT     = 2'd2
  } state_e;

endpackage

// File: rtl/micro_sequencer_if.sv
// Microword / status bundle between the control store and the micro_sequencer.
// master = control-store side, slave = sequencer side.
interface micro_sequencer_if #(
  parameter int CAR_W = 8,
  parameter int OPC_W = 7
) ();

  logic [CAR_W-1:0] i_na;
  logic [2:0]       i_ms;
  logic             i_il;
  logic             i_fetch;
  logic             i_mem_ready;
  logic             i_halt;
  logic [OPC_W-1:0] i_opcode;
  logic [3:0]       i_flags;
  logic             i_call;
  logic             i_ret;
  logic [CAR_W-1:0] o_car;
  logic             o_il;
  logic             o_stall;
  logic             o_halted;
  logic             o_err;

  modport master (
    output i_na, i_ms, i_il, i_fetch, i_mem_ready, i_halt, i_opcode, i_flags, i_call, i_ret,
    input  o_car, o_il, o_stall, o_halted, o_err
  );

  modport slave (
    input  i_na, i_ms, i_il, i_fetch, i_mem_ready, i_halt, i_opcode, i_flags, i_call, i_ret,
    output o_car, o_il, o_stall, o_halted, o_err
  );

endinterface

// File: rtl/micro_sequencer_call_stack.sv
// useq_call_stack: small LIFO of micro-call return addresses. Push when full and
// pop when empty are ignored here; the sequencer decides how to report them.
module useq_call_stack #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_din,
  output logic [W-1:0] o_dout,
  output logic         o_full,
  output logic         o_empty
);

  localparam int SP_W  = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]    mem_q [DEPTH];
  logic [SP_W-1:0] sp_q;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] top_idx;

  assign o_full  = (sp_q == SP_W'(DEPTH));
  assign o_empty = (sp_q == '0);
  assign wr_idx  = IDX_W'(sp_q);
  assign top_idx = IDX_W'(sp_q - SP_W'(1));
  assign o_dout  = mem_q[top_idx];

  // NOTE: storage has no reset; the stack pointer alone defines which entries are valid.
  always_ff @(posedge i_clk) begin
    if (i_push && !o_full) begin
      mem_q[wr_idx] <= i_din;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      sp_q <= '0;
    end else if (i_pop && !o_empty) begin
      sp_q <= sp_q - SP_W'(1);
    end else if (i_push && !o_full) begin
      sp_q <= sp_q + SP_W'(1);
    end
  end

endmodule

// File: rtl/micro_sequencer.sv
// Next-address sequencer: CAR register, next-address select, memory-wait stall,
// halt, and IR load gating. Define USEQ_CALL_STACK_EN to add micro-call/return.
module micro_sequencer
  import useq_pkg::*;
#(
  parameter int CAR_W       = 8,
  parameter int OPC_W       = 7,
  parameter int RESET_VEC   = 0,
  parameter int STACK_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  micro_sequencer_if.slave  bus
);

  localparam logic [CAR_W-1:0] RESET_CAR = CAR_W'(RESET_VEC);

  state_e           state_q, state_d;
  logic [CAR_W-1:0] car_q, car_d;
  logic [CAR_W-1:0] car_inc;
  logic [CAR_W-1:0] sel_addr;
  logic             mem_wait;
  logic             commit;

  assign car_inc  = car_q + CAR_W'(1);
  assign mem_wait = bus.i_fetch & ~bus.i_mem_ready;

`ifdef USEQ_CALL_STACK_EN
  logic             err_q, err_d;
  logic             stk_push, stk_pop, stk_full, stk_empty;
  logic [CAR_W-1:0] stk_dout;

  useq_call_stack #(
    .W     (CAR_W),
    .DEPTH (STACK_DEPTH)
  ) u_call_stack (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_push  (stk_push),
    .i_pop   (stk_pop),
    .i_din   (car_inc),
    .o_dout  (stk_dout),
    .o_full  (stk_full),
    .o_empty (stk_empty)
  );
`else
  logic unused_call_ret;
  assign unused_call_ret = bus.i_call ^ bus.i_ret;
`endif

  // Flags are read here in the committing cycle, so a WAIT_MEM exit sees fresh flags.
  always_comb begin
    sel_addr = car_inc;
    unique case (bus.i_ms)
      MS_INC: sel_addr = car_inc;
      MS_NA:  sel_addr = bus.i_na;
      MS_C:   sel_addr = bus.i_flags[FLAG_C] ? bus.i_na : car_inc;
      MS_V:   sel_addr = bus.i_flags[FLAG_V] ? bus.i_na : car_inc;
      MS_Z:   sel_addr = bus.i_flags[FLAG_Z] ? bus.i_na : car_inc;
      MS_N:   sel_addr = bus.i_flags[FLAG_N] ? bus.i_na : car_inc;
      MS_NZ:  sel_addr = bus.i_flags[FLAG_Z] ? car_inc : bus.i_na;
      MS_MAP: sel_addr = CAR_W'({1'b1, bus.i_opcode});
      default: sel_addr = car_inc;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= RUN;
      car_q   <= RESET_CAR;
`ifdef USEQ_CALL_STACK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      car_q   <= car_d;
`ifdef USEQ_CALL_STACK_EN
      err_q   <= err_d;
`endif
    end
  end

  // NOTE: every signal written below gets a default first, so no latch can be inferred.
  always_comb begin
    state_d = state_q;
    car_d   = car_q;
    commit  = 1'b0;
`ifdef USEQ_CALL_STACK_EN
    err_d    = err_q;
    stk_push = 1'b0;
    stk_pop  = 1'b0;
`endif
    unique case (state_q)
      RUN: begin
        if (bus.i_halt) begin
          state_d = HALT;
        end else if (mem_wait) begin
          state_d = WAIT_MEM;
        end else begin
          commit = 1'b1;
        end
      end
      WAIT_MEM: begin
        if (bus.i_mem_ready) begin
          commit  = 1'b1;
          state_d = RUN;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = RUN;
    endcase

    if (commit) begin
      car_d = sel_addr;
`ifdef USEQ_CALL_STACK_EN
      // Return beats call; an empty-stack return restarts the fetch microroutine.
      if (bus.i_ret) begin
        if (stk_empty) begin
          car_d = RESET_CAR;
          err_d = 1'b1;
        end else begin
          car_d   = stk_dout;
          stk_pop = 1'b1;
        end
      end else if (bus.i_call) begin
        car_d = bus.i_na;
        if (stk_full) begin
          err_d = 1'b1;
        end else begin
          stk_push = 1'b1;
        end
      end
`endif
    end
  end

  always_comb begin
    bus.o_car    = car_q;
    bus.o_stall  = (state_q == WAIT_MEM);
    bus.o_halted = (state_q == HALT);
    bus.o_il     = bus.i_il & (state_q == RUN) & ~mem_wait & ~bus.i_halt & i_rstn;
`ifdef USEQ_CALL_STACK_EN
    bus.o_err    = err_q;
`else
    bus.o_err    = 1'b0;
`endif
  end

endmodule
